// File: rtl/serial_word_collector.sv
// Collects WIDTH qualified serial bits into a word and presents it through a
// one-entry valid/ready holding register; words lost to backpressure set a sticky overflow flag.
module serial_word_collector #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow,
  input  logic             overflow_clr
);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] word_next;
  logic             last;
  logic             drain;

  // word_next doubles as the shifted partial word and, on the last bit, the completed word
  always_comb begin
    word_next = sreg;
    if (MSB_FIRST) word_next = {sreg[WIDTH-2:0], din};
    else           word_next = {din, sreg[WIDTH-1:1]};
  end

  assign last  = din_valid && (bit_count == CNT_W'(WIDTH-1));
  assign drain = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg       <= '0;
      bit_count  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (last) begin
        sreg      <= '0;
        bit_count <= '0;
      end else if (din_valid) begin
        sreg      <= word_next;
        bit_count <= bit_count + CNT_W'(1);
      end

      // a full register drained on the completion edge reloads without a bubble
      if (last && (!dout_valid || dout_ready)) begin
        dout       <= word_next;
        dout_valid <= 1'b1;
      end else if (drain) begin
        dout_valid <= 1'b0;
      end

      // a drop beats a simultaneous clear
      if (last && dout_valid && !dout_ready) overflow <= 1'b1;
      else if (overflow_clr)                 overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector: one MSB-first and one LSB-first
// instance share the same serial stimulus.
module tb_serial_word_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       dout_ready = 1'b0;
  logic       overflow_clr = 1'b0;

  logic [7:0] m_dout, l_dout;
  logic       m_vld, l_vld;
  logic [2:0] m_cnt, l_cnt;
  logic       m_ovf, l_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_word_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(m_dout), .dout_valid(m_vld), .dout_ready(dout_ready),
    .bit_count(m_cnt), .overflow(m_ovf), .overflow_clr(overflow_clr)
  );

  serial_word_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .dout(l_dout), .dout_valid(l_vld), .dout_ready(dout_ready),
    .bit_count(l_cnt), .overflow(l_ovf), .overflow_clr(overflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    din = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // stream order is w[7] first
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bit_in(w[i]);
  endtask

  initial begin
    int gaps [7] = '{0, 2, 1, 3, 0, 1, 2};
    logic [7:0] w;

    // reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_dout", m_dout, 0);
    check("rst_vld", m_vld, 0);
    check("rst_cnt", m_cnt, 0);
    check("rst_ovf", m_ovf, 0);

    // 1: consecutive B2 stream, ready high
    dout_ready = 1'b1;
    w = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      bit_in(w[i]);
      check("t1_cnt", m_cnt, (8 - i) % 8);
      if (i != 0) check("t1_vld_pre", m_vld, 0);
    end
    check("t1_dout", m_dout, 8'hB2);
    check("t1_vld", m_vld, 1);
    check("t2_lsb_dout", l_dout, 8'h4D);
    tick();
    check("t1_vld_one_cycle", m_vld, 0);

    // 2: same stream with gaps, LSB-first instance
    for (int i = 7; i >= 0; i--) begin
      bit_in(w[i]);
      if (i != 0) begin
        for (int g = 0; g < gaps[7-i]; g++) begin
          tick();
          check("t2_cnt_hold", l_cnt, 8 - i);
        end
      end
    end
    check("t2_gap_dout", l_dout, 8'h4D);
    check("t2_gap_vld", l_vld, 1);
    check("t2_gap_msb", m_dout, 8'hB2);
    tick();
    check("t2_drain", l_vld, 0);

    // 3: backpressure drops the second word
    dout_ready = 1'b0;
    send_word(8'hB2);
    check("t3_first_vld", m_vld, 1);
    check("t3_first_ovf", m_ovf, 0);
    send_word(8'h0F);
    check("t3_dout_kept", m_dout, 8'hB2);
    check("t3_vld_kept", m_vld, 1);
    check("t3_ovf_set", m_ovf, 1);
    check("t3_cnt_wrap", m_cnt, 0);
    dout_ready = 1'b1;
    tick();
    check("t3_drain", m_vld, 0);
    check("t3_ovf_sticky", m_ovf, 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t3_ovf_clr", m_ovf, 0);

    // 4: drain and completion on the same edge
    dout_ready = 1'b0;
    send_word(8'hB2);
    check("t4_hold", m_dout, 8'hB2);
    w = 8'h3C;
    for (int i = 7; i >= 1; i--) bit_in(w[i]);
    check("t4_vld_before", m_vld, 1);
    dout_ready = 1'b1;
    bit_in(w[0]);
    check("t4_dout", m_dout, 8'h3C);
    check("t4_vld", m_vld, 1);
    check("t4_ovf", m_ovf, 0);
    tick();
    check("t4_drain", m_vld, 0);

    // drop and clear on the same edge: set wins
    dout_ready = 1'b0;
    send_word(8'h11);
    w = 8'h22;
    for (int i = 7; i >= 1; i--) bit_in(w[i]);
    overflow_clr = 1'b1;
    bit_in(w[0]);
    overflow_clr = 1'b0;
    check("ovf_set_wins", m_ovf, 1);
    check("ovf_dout_kept", m_dout, 8'h11);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr2", m_ovf, 0);
    dout_ready = 1'b1;
    tick();
    check("drain2", m_vld, 0);

    // 5: reset mid-word, then reset while holding a word
    for (int i = 0; i < 5; i++) bit_in(i[0]);
    check("t5_cnt5", m_cnt, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_cnt_rst", m_cnt, 0);
    dout_ready = 1'b0;
    send_word(8'hA5);
    check("t5_dout", m_dout, 8'hA5);
    check("t5_vld", m_vld, 1);
    check("t5_ovf", m_ovf, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_vld", m_vld, 0);
    check("t5_rst_dout", m_dout, 0);

    // 6: reset pulse between edges has no effect
    send_word(8'hB2);
    bit_in(1'b1);
    bit_in(1'b0);
    bit_in(1'b1);
    check("t6_cnt_pre", m_cnt, 3);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    check("t6_cnt", m_cnt, 3);
    check("t6_vld", m_vld, 1);
    check("t6_dout", m_dout, 8'hB2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Downstream consumer of the single-bit registered stream produced by the team's D flip-flop stage (its q output feeds din here).
- Gathers WIDTH qualified serial bits into a parallel word.
- Presents the word on a valid/ready output port through a one-entry holding register.
- Flags words lost to backpressure with a sticky overflow bit.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first received bit lands in dout[0].
- CNT_W, $clog2(WIDTH), width of bit_count.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset; sampled only on rising clk.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on a rising clk edge only when din_valid=1.
- dout  output  WIDTH  assembled word; stable while dout_valid=1 and dout_ready=0.
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
- bit_count  output  CNT_W  bits accepted into the current partial word, 0..WIDTH-1.
- overflow  output  1  sticky: a completed word was dropped.
- overflow_clr  input  1  clears overflow.

Behaviour:
- Reset (sync, active-high). On a rising edge with reset=1:
  - shift register=0, bit_count=0, dout=0, dout_valid=0, overflow=0.
  - All other inputs are ignored that cycle.
  - Reset mid-word discards the partial word. Reset while dout_valid=1 discards the held word.
- Bit accept:
  - Each edge with din_valid=1 shifts din into the shift register and increments bit_count.
  - din_valid=0: shift register and bit_count hold. Gaps of any length are legal.
- Bit ordering:
  - MSB_FIRST=1: shift left, din enters bit 0. After WIDTH bits, the first bit sits in bit WIDTH-1.
  - MSB_FIRST=0: shift right, din enters bit WIDTH-1. After WIDTH bits, the first bit sits in bit 0.
- Word completion: the edge that accepts bit WIDTH (bit_count==WIDTH-1 and din_valid=1) is the completion edge.
  - The completed word is formed from the shift register plus the current din.
  - bit_count wraps to 0 and the shift register clears.
  - Latency: dout/dout_valid reflect the word in the cycle after the completion edge. No combinational path from din to dout.
- Holding register, resolved at the completion edge:
  - Empty (dout_valid=0): load word, dout_valid=1.
  - Full and drained on the same edge (dout_ready=1): load new word, dout_valid stays 1, no bubble.
  - Full and not drained: new word dropped, dout/dout_valid unchanged, overflow=1. Collection continues with the next bit.
- Drain without completion: dout_valid=1 and dout_ready=1 gives dout_valid=0 next cycle. dout holds its last value; no clearing is required.
- dout_ready is ignored while dout_valid=0.
- Overflow:
  - Set by a drop; cleared by overflow_clr=1.
  - Drop and clear on the same edge: set wins, overflow=1.
- All outputs are registered.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, dout_ready=1: din 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles -> dout=8'hB2, dout_valid=1 for exactly one cycle, starting the cycle after the 8th bit; bit_count sequence 1..7 then 0.
2. Same bits with MSB_FIRST=0 -> dout=8'h4D; then the same stream with din_valid=0 inserted randomly between bits -> identical dout, and bit_count holds across gaps.
3. Backpressure: dout_ready=0, send 8'hB2 then 8'h0F (MSB first) -> dout stays 8'hB2, overflow=1 after the 16th bit; then dout_ready=1 -> dout_valid=0 next cycle; overflow_clr=1 -> overflow=0.
4. Simultaneous drain and completion: dout_valid=1 holding 8'hB2, dout_ready=1 on the completion edge of 8'h3C -> dout=8'h3C with dout_valid continuously 1, overflow=0.
5. Reset mid-word: 5 bits accepted, reset=1 for one edge, then bits of 8'hA5 -> bit_count=0 after reset, dout=8'hA5 (no leftover bits), overflow=0; reset asserted while dout_valid=1 -> dout_valid=0, dout=0 next cycle.
6. Reset synchronicity: reset pulsed high between clock edges and low before the next edge -> no state change.
